// File: rtl/pcileech_rmii_rx.sv
// ---------------------------------------------------------------------------
// pcileech_rmii_rx
//
// RMII receive path. Turns the 2-bit RMII receive stream into a byte stream
// with frame delimiters, and keeps running counts of good and bad frames.
//
// Ports
//   clk           50 MHz RMII reference clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   eth_crs_dv    RMII carrier-sense / data-valid from the PHY
//   eth_rx_data   RMII receive dibit, bit 0 first in time
//   eth_rx_err    PHY receive error
//   rx_data       received byte, meaningful only while rx_valid=1
//   rx_valid      one-cycle strobe per byte, no backpressure
//   rx_sof        marks the first byte of a frame
//   rx_eof        marks the last byte of a frame
//   rx_err        frame bad, meaningful only with rx_eof=1
//   rx_frame_cnt  good frame count (wraps)
//   rx_drop_cnt   bad / dropped frame count (wraps)
// ---------------------------------------------------------------------------
module pcileech_rmii_rx #(
    parameter int MIN_FRAME_BYTES = 64,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eth_crs_dv,
    input  logic [1:0]  eth_rx_data,
    input  logic        eth_rx_err,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic [15:0] rx_frame_cnt,
    output logic [15:0] rx_drop_cnt
);

    typedef enum logic [2:0] {
        ST_SYNC     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_DATA     = 3'd3,
        ST_DROP     = 3'd4
    } state_t;

    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_BYTES);
    // Byte count just before the truncating byte completes
    localparam logic [10:0] LAST_CNT = 11'(MAX_FRAME_BYTES - 1);

    logic        crs_s1_r;
    logic [1:0]  dat_s1_r;
    state_t      state_r;
    state_t      state_next_s;
    logic [5:0]  shift_r;
    logic [1:0]  idx_r;
    logic [10:0] byte_cnt_r;
    logic [7:0]  held_r;
    logic        err_seen_r;
    logic        trunc_pend_r;

    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        rx_sof_r;
    logic        rx_eof_r;
    logic        rx_err_r;
    logic [15:0] frame_cnt_r;
    logic [15:0] drop_cnt_r;

    logic        dibit_valid_s;
    logic        eoc_s;
    logic        sfd_s;
    logic        byte_done_s;
    logic        trunc_s;
    logic        frame_err_s;
    logic [7:0]  new_byte_s;
    logic        out_valid_s;
    logic        out_sof_s;
    logic        out_eof_s;
    logic        out_err_s;
    logic [7:0]  out_data_s;
    logic        drop_evt_s;
    logic [1:0]  drop_inc_s;

    // The S1 dibit is still data when either neighbour has crs_dv high, so
    // the RMII mid-frame toggle of crs_dv never ends a frame early.
    assign dibit_valid_s = crs_s1_r | eth_crs_dv;
    assign eoc_s         = ~(crs_s1_r | eth_crs_dv);
    assign sfd_s         = (state_r == ST_PREAMBLE) && dibit_valid_s && (dat_s1_r == 2'b11);
    assign byte_done_s   = (state_r == ST_DATA) && dibit_valid_s && (idx_r == 2'd3);
    assign new_byte_s    = {dat_s1_r, shift_r};
    assign trunc_s       = byte_done_s && (byte_cnt_r == LAST_CNT);
    assign frame_err_s   = err_seen_r | eth_rx_err | (idx_r != 2'd0) | (byte_cnt_r < MIN_CNT);
    assign drop_inc_s    = {1'b0, rx_eof_r & rx_err_r} + {1'b0, drop_evt_s};

    // Input stage S1: one register on the raw RMII pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crs_s1_r <= 1'b0;
            dat_s1_r <= 2'b00;
        end else begin
            crs_s1_r <= eth_crs_dv;
            dat_s1_r <= eth_rx_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_SYNC: begin
                if (eoc_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SYNC;
                end
            end
            ST_IDLE: begin
                if (dibit_valid_s && (dat_s1_r == 2'b01)) begin
                    state_next_s = ST_PREAMBLE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (eoc_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    case (dat_s1_r)
                        2'b11:   state_next_s = ST_DATA;
                        2'b10:   state_next_s = ST_DROP;
                        default: state_next_s = ST_PREAMBLE;
                    endcase
                end
            end
            ST_DATA: begin
                if (eoc_s) begin
                    state_next_s = ST_IDLE;
                end else if (trunc_s) begin
                    state_next_s = ST_DROP;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_DROP: begin
                if (eoc_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            default: begin
                state_next_s = ST_SYNC;
            end
        endcase
    end

    // FSM outputs: byte emission, delimiters and drop events
    always_comb begin
        out_valid_s = 1'b0;
        out_sof_s   = 1'b0;
        out_eof_s   = 1'b0;
        out_err_s   = 1'b0;
        out_data_s  = 8'h00;
        drop_evt_s  = 1'b0;
        if (trunc_pend_r) begin
            // Truncating byte goes out the cycle after the held byte drained
            out_valid_s = 1'b1;
            out_eof_s   = 1'b1;
            out_err_s   = 1'b1;
            out_data_s  = held_r;
        end else begin
            case (state_r)
                ST_DATA: begin
                    if (eoc_s) begin
                        if (byte_cnt_r != 11'd0) begin
                            out_valid_s = 1'b1;
                            out_eof_s   = 1'b1;
                            out_sof_s   = (byte_cnt_r == 11'd1);
                            out_err_s   = frame_err_s;
                            out_data_s  = held_r;
                        end else begin
                            drop_evt_s  = 1'b1;
                        end
                    end else if (byte_done_s && (byte_cnt_r != 11'd0)) begin
                        // Held byte is released when its successor completes
                        out_valid_s = 1'b1;
                        out_sof_s   = (byte_cnt_r == 11'd1);
                        out_data_s  = held_r;
                    end else begin
                        out_valid_s = 1'b0;
                    end
                end
                ST_PREAMBLE: begin
                    if (dibit_valid_s && (dat_s1_r == 2'b10)) begin
                        drop_evt_s = 1'b1;
                    end else begin
                        drop_evt_s = 1'b0;
                    end
                end
                default: begin
                    drop_evt_s = 1'b0;
                end
            endcase
        end
    end

    // Byte assembly, byte count, error accumulation and truncation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r      <= 6'd0;
            idx_r        <= 2'd0;
            byte_cnt_r   <= 11'd0;
            held_r       <= 8'h00;
            err_seen_r   <= 1'b0;
            trunc_pend_r <= 1'b0;
        end else begin
            if (sfd_s) begin
                shift_r    <= 6'd0;
                idx_r      <= 2'd0;
                byte_cnt_r <= 11'd0;
                err_seen_r <= 1'b0;
            end else if ((state_r == ST_DATA) && dibit_valid_s) begin
                shift_r <= {dat_s1_r, shift_r[5:2]};
                idx_r   <= idx_r + 2'd1;
                if (idx_r == 2'd3) begin
                    held_r     <= new_byte_s;
                    byte_cnt_r <= byte_cnt_r + 11'd1;
                end
            end
            if ((state_r == ST_DATA) && eth_rx_err) begin
                err_seen_r <= 1'b1;
            end
            trunc_pend_r <= trunc_s;
        end
    end

    // Registered byte-stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_sof_r   <= 1'b0;
            rx_eof_r   <= 1'b0;
            rx_err_r   <= 1'b0;
        end else begin
            rx_data_r  <= out_data_s;
            rx_valid_r <= out_valid_s;
            rx_sof_r   <= out_sof_s;
            rx_eof_r   <= out_eof_s;
            rx_err_r   <= out_err_s;
        end
    end

    // Frame counters, updated the cycle after rx_eof
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'd0;
            drop_cnt_r  <= 16'd0;
        end else begin
            if (rx_eof_r && !rx_err_r) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            drop_cnt_r <= drop_cnt_r + {14'd0, drop_inc_s};
        end
    end

    assign rx_data      = rx_data_r;
    assign rx_valid     = rx_valid_r;
    assign rx_sof       = rx_sof_r;
    assign rx_eof       = rx_eof_r;
    assign rx_err       = rx_err_r;
    assign rx_frame_cnt = frame_cnt_r;
    assign rx_drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_pcileech_rmii_rx.sv
// ---------------------------------------------------------------------------
// tb_pcileech_rmii_rx
//
// Drives whole RMII frames (preamble, SFD, payload, optional trailing
// dibits, optional crs_dv toggle, error pulse or reset) into the receiver,
// records every emitted byte and compares against expectations taken from
// a vector table, a few hand-written sequences and a frame-level model.
// ---------------------------------------------------------------------------
module tb_pcileech_rmii_rx;

    localparam int MIN_B = 64;
    localparam int MAX_B = 1522;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        eth_crs_dv = 1'b0;
    logic [1:0]  eth_rx_data = 2'b00;
    logic        eth_rx_err = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_err;
    logic [15:0] rx_frame_cnt;
    logic [15:0] rx_drop_cnt;

    pcileech_rmii_rx #(
        .MIN_FRAME_BYTES (MIN_B),
        .MAX_FRAME_BYTES (MAX_B)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .eth_crs_dv   (eth_crs_dv),
        .eth_rx_data  (eth_rx_data),
        .eth_rx_err   (eth_rx_err),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_sof       (rx_sof),
        .rx_eof       (rx_eof),
        .rx_err       (rx_err),
        .rx_frame_cnt (rx_frame_cnt),
        .rx_drop_cnt  (rx_drop_cnt)
    );

    always #10 clk = ~clk;

    typedef struct {
        int nbytes;
        int extra;
        bit toggle;
        int err_byte;
        int exp_n;
        bit exp_err;
        int exp_gap;
        int good_inc;
        int drop_inc;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         exp_frame_cnt = 0;
    int         exp_drop_cnt = 0;
    logic [7:0] tx_bytes [$];
    logic [7:0] got_data [$];
    bit         got_sof [$];
    bit         got_eof [$];
    bit         got_err [$];
    int         got_cyc [$];

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid) begin
            got_data.push_back(rx_data);
            got_sof.push_back(rx_sof);
            got_eof.push_back(rx_eof);
            got_err.push_back(rx_err);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic clear_got();
        got_data.delete();
        got_sof.delete();
        got_eof.delete();
        got_err.delete();
        got_cyc.delete();
    endtask

    task automatic drive_raw(input bit crs, input logic [1:0] d);
        @(posedge clk);
        #1;
        eth_crs_dv  = crs;
        eth_rx_data = d;
        eth_rx_err  = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            drive_raw(1'b0, 2'b00);
        end
    endtask

    // Frame-level reference: what the receiver must report for a frame of
    // n payload bytes followed by 'extra' stray dibits.
    function automatic void model_frame(input int n, input int extra, input bit errp,
                                        output int out_n, output bit out_err,
                                        output int gap, output int good_inc,
                                        output int drop_inc);
        bit trunc;
        trunc = (n >= MAX_B);
        out_n = trunc ? MAX_B : n;
        if (n == 0) begin
            out_err  = 1'b0;
            gap      = 0;
            good_inc = 0;
            drop_inc = 1;
        end else begin
            out_err  = trunc || errp || (extra != 0) || (n < MIN_B);
            gap      = trunc ? 1 : 1 + extra;
            good_inc = out_err ? 0 : 1;
            drop_inc = out_err ? 1 : 0;
        end
    endfunction

    // Sends preamble + SFD + tx_bytes[0..n-1] + extra dibits, then idles
    task automatic send_frame(input int n, input int extra, input bit toggle,
                              input int err_byte, input int rst_byte);
        bit         dv_q [$];
        logic [1:0] dd_q [$];
        bit         de_q [$];
        bit         dr_q [$];
        logic [7:0] b;
        int         total;
        clear_got();
        for (int i = 0; i < 8; i++) begin
            b = (i == 7) ? 8'hd5 : 8'h55;
            for (int j = 0; j < 4; j++) begin
                dd_q.push_back(b[2*j +: 2]);
                dv_q.push_back(1'b1);
                de_q.push_back(1'b0);
                dr_q.push_back(1'b0);
            end
        end
        for (int i = 0; i < n; i++) begin
            b = tx_bytes[i];
            for (int j = 0; j < 4; j++) begin
                dd_q.push_back(b[2*j +: 2]);
                dv_q.push_back(1'b1);
                de_q.push_back((i == err_byte) && (j == 0));
                dr_q.push_back((i == rst_byte) && (j < 3));
            end
        end
        for (int i = 0; i < extra; i++) begin
            dd_q.push_back(2'($urandom_range(0, 3)));
            dv_q.push_back(1'b1);
            de_q.push_back(1'b0);
            dr_q.push_back(1'b0);
        end
        total = dv_q.size();
        if (toggle) begin
            for (int k = total - 8; k < total; k++) begin
                dv_q[k] = (((k - (total - 8)) % 2) == 1);
            end
        end
        for (int k = 0; k < total; k++) begin
            @(posedge clk);
            #1;
            eth_crs_dv  = dv_q[k];
            eth_rx_data = dd_q[k];
            eth_rx_err  = de_q[k];
            if (dr_q[k]) begin
                rst_n = 1'b0;
                if ((k > 0) && dr_q[k-1]) begin
                    check_int("in_reset_outputs",
                              int'({rx_valid, rx_sof, rx_eof, rx_err, rx_data}) +
                              int'(rx_frame_cnt) + int'(rx_drop_cnt), 0);
                end
            end else if (!rst_n) begin
                rst_n = 1'b1;
                clear_got();
                exp_frame_cnt = 0;
                exp_drop_cnt  = 0;
            end
        end
        idle_gap(12);
    endtask

    task automatic check_frame(input string name, input int exp_n, input bit exp_err,
                               input int exp_gap);
        int bad;
        check_int($sformatf("%s count", name), got_data.size(), exp_n);
        if ((exp_n > 0) && (got_data.size() == exp_n)) begin
            bad = 0;
            for (int i = 0; i < exp_n; i++) begin
                if (got_data[i] !== tx_bytes[i]) bad++;
            end
            check_int($sformatf("%s bad_bytes", name), bad, 0);
            bad = 0;
            for (int i = 0; i < exp_n; i++) begin
                if (got_sof[i] != (i == 0)) bad++;
                if (got_eof[i] != (i == exp_n - 1)) bad++;
            end
            check_int($sformatf("%s bad_delims", name), bad, 0);
            check_int($sformatf("%s eof_err", name), int'(got_err[exp_n-1]), int'(exp_err));
            bad = 0;
            for (int i = 1; i < exp_n - 1; i++) begin
                if (got_cyc[i] - got_cyc[i-1] != 4) bad++;
            end
            check_int($sformatf("%s bad_spacing", name), bad, 0);
            if (exp_n > 1) begin
                check_int($sformatf("%s last_gap", name),
                          got_cyc[exp_n-1] - got_cyc[exp_n-2], exp_gap);
            end
        end
        check_int($sformatf("%s frame_cnt", name), int'(rx_frame_cnt), exp_frame_cnt & 16'hffff);
        check_int($sformatf("%s drop_cnt", name), int'(rx_drop_cnt), exp_drop_cnt & 16'hffff);
    endtask

    task automatic fill_ramp(input int n);
        tx_bytes.delete();
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'(i));
    endtask

    vec_t vecs [13];

    initial begin
        int n, extra, eb, out_n, gap, gi, di;
        bit tog, oerr;

        vecs[0]  = '{64,   0, 1'b0, -1, 64,   1'b0, 1, 1, 0};
        vecs[1]  = '{64,   0, 1'b1, -1, 64,   1'b0, 1, 1, 0};
        vecs[2]  = '{10,   0, 1'b0, -1, 10,   1'b1, 1, 0, 1};
        vecs[3]  = '{64,   1, 1'b0, -1, 64,   1'b1, 2, 0, 1};
        vecs[4]  = '{100,  0, 1'b0, 20, 100,  1'b1, 1, 0, 1};
        vecs[5]  = '{1600, 0, 1'b0, -1, 1522, 1'b1, 1, 0, 1};
        vecs[6]  = '{64,   0, 1'b0, -1, 64,   1'b0, 1, 1, 0};
        vecs[7]  = '{65,   3, 1'b1, -1, 65,   1'b1, 4, 0, 1};
        vecs[8]  = '{0,    0, 1'b0, -1, 0,    1'b0, 0, 0, 1};
        vecs[9]  = '{1,    0, 1'b0, -1, 1,    1'b1, 0, 0, 1};
        vecs[10] = '{1522, 0, 1'b0, -1, 1522, 1'b1, 1, 0, 1};
        vecs[11] = '{1521, 0, 1'b0, -1, 1521, 1'b0, 1, 1, 0};
        vecs[12] = '{63,   0, 1'b0, -1, 63,   1'b1, 1, 0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_outputs",
                  int'({rx_valid, rx_sof, rx_eof, rx_err, rx_data}), 0);
        check_int("reset_counters", int'(rx_frame_cnt) + int'(rx_drop_cnt), 0);
        rst_n = 1'b1;
        idle_gap(5);

        // Table-driven frames
        for (int v = 0; v < 13; v++) begin
            fill_ramp(vecs[v].nbytes);
            send_frame(vecs[v].nbytes, vecs[v].extra, vecs[v].toggle, vecs[v].err_byte, -1);
            exp_frame_cnt += vecs[v].good_inc;
            exp_drop_cnt  += vecs[v].drop_inc;
            check_frame($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].exp_err, vecs[v].exp_gap);
        end

        // Bad dibit inside preamble: dropped once, no output
        clear_got();
        drive_raw(1'b1, 2'b01);
        drive_raw(1'b1, 2'b01);
        drive_raw(1'b1, 2'b01);
        drive_raw(1'b1, 2'b10);
        for (int i = 0; i < 6; i++) drive_raw(1'b1, 2'b01);
        idle_gap(12);
        exp_drop_cnt += 1;
        check_int("badpre count", got_data.size(), 0);
        check_int("badpre drop_cnt", int'(rx_drop_cnt), exp_drop_cnt);

        // Preamble without SFD, then carrier loss: nothing counted
        for (int i = 0; i < 8; i++) drive_raw(1'b1, 2'b01);
        idle_gap(12);
        check_int("presfd count", got_data.size(), 0);
        check_int("presfd drop_cnt", int'(rx_drop_cnt), exp_drop_cnt);
        check_int("presfd frame_cnt", int'(rx_frame_cnt), exp_frame_cnt);

        // Idle noise not starting with 01 is ignored
        drive_raw(1'b1, 2'b00);
        drive_raw(1'b1, 2'b10);
        drive_raw(1'b1, 2'b11);
        drive_raw(1'b1, 2'b00);
        idle_gap(12);
        check_int("noise count", got_data.size(), 0);
        check_int("noise drop_cnt", int'(rx_drop_cnt), exp_drop_cnt);

        // Randomized frames against the frame-level model
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 150);
            if ($urandom_range(0, 9) == 0) n = $urandom_range(1515, 1530);
            extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            tog = 1'($urandom_range(0, 1));
            eb = -1;
            if ((n >= 2) && ($urandom_range(0, 3) == 0)) begin
                eb = $urandom_range(1, ((n < MAX_B) ? n : MAX_B) - 1);
            end
            tx_bytes.delete();
            for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
            model_frame(n, extra, (eb >= 0), out_n, oerr, gap, gi, di);
            send_frame(n, extra, tog, eb, -1);
            exp_frame_cnt += gi;
            exp_drop_cnt  += di;
            check_frame($sformatf("rnd%0d_n%0d_x%0d", r, n, extra), out_n, oerr, gap);
        end

        // Reset mid-frame at byte 30 for 3 cycles, carrier held high
        fill_ramp(64);
        send_frame(64, 0, 1'b0, -1, 30);
        check_frame("rst_mid", 0, 1'b0, 0);

        // Next frame after the reset is received normally
        send_frame(64, 0, 1'b0, -1, -1);
        exp_frame_cnt += 1;
        check_frame("post_rst", 64, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
